// File: rtl/alu_pkg.sv
// alu_pkg: opcode width and function-select encodings shared by the ALU files.
package alu_pkg;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [OP_W-1:0] ALU_OR   = 3'b010;
    localparam logic [OP_W-1:0] ALU_AND  = 3'b011;
    localparam logic [OP_W-1:0] ALU_XOR  = 3'b100;
    localparam logic [OP_W-1:0] ALU_NOR  = 3'b101;
    localparam logic [OP_W-1:0] ALU_SLT  = 3'b110;
    localparam logic [OP_W-1:0] ALU_SLTU = 3'b111;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational function select producing the next ALU result.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  ALUOp,
    output logic [WIDTH-1:0] next_c
);
    always_comb begin
        next_c = '0;
        case (ALUOp)
            ALU_ADD:  next_c = A + B;
            ALU_SUB:  next_c = A - B;
            ALU_OR:   next_c = A | B;
            ALU_AND:  next_c = A & B;
            ALU_XOR:  next_c = A ^ B;
            ALU_NOR:  next_c = ~(A | B);
            ALU_SLT:  next_c = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU: next_c = {{(WIDTH-1){1'b0}}, A < B};
            default:  next_c = '0;
        endcase
    end
endmodule

// File: rtl/alu.sv
// alu: registered 32-bit MIPS ALU, one-cycle latency, synchronous active-high reset.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  ALUOp,
    output logic [WIDTH-1:0] C
);
    logic [WIDTH-1:0] next_c;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .A(A),
        .B(B),
        .ALUOp(ALUOp),
        .next_c(next_c)
    );

    always_ff @(posedge clk)
        C <= reset ? '0 : next_c;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against an arithmetic reference model.
module tb_alu;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B, C;
    logic [2:0]  ALUOp;
    int vectors = 0;
    int miscompares = 0;

    alu dut (
        .clk(clk),
        .reset(reset),
        .A(A),
        .B(B),
        .ALUOp(ALUOp),
        .C(C)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint unsigned m = 64'h1_0000_0000;
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        case (op)
            3'd0: return 32'((ua + ub) % m);
            3'd1: return 32'((m + ua - ub) % m);
            3'd2: return a | b;
            3'd3: return a & b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return (ua < ub) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: C=%08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        reset = r;
        A = a;
        B = b;
        ALUOp = op;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic [31:0] exp);
        apply(1'b0, a, b, op);
        check(tag, C, exp);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  op;
        logic        r;
        apply(1'b1, 32'hffffffff, 32'hffffffff, 3'd0);
        check("reset0", C, 32'h0);
        apply(1'b1, 32'hffffffff, 32'hffffffff, 3'd0);
        check("reset1", C, 32'h0);
        directed("post_reset_add", 32'hffffffff, 32'hffffffff, 3'd0, 32'hfffffffe);
        directed("or",   32'h000000ff, 32'h000000ff, 3'd2, 32'h000000ff);
        directed("and",  32'h000000ff, 32'h000000ff, 3'd3, 32'h000000ff);
        directed("xor",  32'h000000ff, 32'h000000ff, 3'd4, 32'h00000000);
        directed("nor",  32'h000000ff, 32'h000000ff, 3'd5, 32'hffffff00);
        directed("add_wrap", 32'hffffffff, 32'h1, 3'd0, 32'h0);
        directed("sub_wrap", 32'h0, 32'h1, 3'd1, 32'hffffffff);
        directed("add_ovf",  32'h7fffffff, 32'h1, 3'd0, 32'h80000000);
        directed("slt_neg",  32'hffffffff, 32'h1, 3'd6, 32'h1);
        directed("sltu_big", 32'hffffffff, 32'h1, 3'd7, 32'h0);
        directed("slt_eq",   32'h89abcdef, 32'h89abcdef, 3'd6, 32'h0);
        directed("sltu_eq",  32'h89abcdef, 32'h89abcdef, 3'd7, 32'h0);
        directed("slt_pos",  32'h1, 32'h80000000, 3'd6, 32'h0);
        directed("sltu_lt",  32'h1, 32'h80000000, 3'd7, 32'h1);
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 32'h12345678, 32'h0f0f0f0f, 3'(i));
            check($sformatf("b2b_op%0d", i), C, model(32'h12345678, 32'h0f0f0f0f, 3'(i)));
        end
        for (int i = 0; i < 8; i++) begin
            r = (i == 4);
            apply(r, 32'h12345678, 32'h0f0f0f0f, 3'(i));
            check($sformatf("b2b_rst_op%0d", i), C, r ? 32'h0 : model(32'h12345678, 32'h0f0f0f0f, 3'(i)));
        end
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = {24'h0, a[7:0]};
            op = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 19) == 0);
            apply(r, a, b, op);
            check($sformatf("rand%0d_op%0d", i, op), C, r ? 32'h0 : model(a, b, op));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
